// File: rtl/sw_cmd_encoder.sv
// -----------------------------------------------------------------------------
// sw_cmd_encoder
//
// Front end for the LED shift datapath. Four raw slide switches are
// synchronized, debounced on a slow sample tick, and every debounced rising
// edge becomes a queued shift command. Commands leave over a valid/ready
// handshake (this block drives valid, the shifter drives ready). When several
// presses are queued, the lowest switch index goes out first.
//
// Ports:
//   clk_in     system clock
//   rst_n      asynchronous active-low reset (synchronous release expected)
//   sw[3:0]    raw switch levels, asynchronous to clk_in
//   cmd_ready  shifter accepts cmd_code this cycle
//   ovf_clr    synchronous clear of the sticky overflow flag
//   cmd_valid  cmd_code holds a valid command
//   cmd_code   index (0..3) of the pressed switch
//   sw_db[3:0] debounced switch levels
//   ovf        sticky: a press was dropped because it was already queued
// -----------------------------------------------------------------------------
module sw_cmd_encoder #(
    parameter int unsigned SAMPLE_DIV   = 4,
    parameter int unsigned DEBOUNCE_CNT = 3,
    parameter int unsigned CNT_W        = 20
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       cmd_ready,
    input  logic       ovf_clr,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic [3:0] sw_db,
    output logic       ovf
);

    localparam int unsigned DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

    // ---------------------------------------------------------------------
    // Two-flop synchronizer
    // ---------------------------------------------------------------------
    logic [3:0] sw_meta;
    logic [3:0] sw_s;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    // ---------------------------------------------------------------------
    // Sample tick: one cycle in every SAMPLE_DIV
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Debounce: the level only follows sw_s after DEBOUNCE_CNT consecutive
    // ticks of disagreement; any agreeing tick restarts the count.
    // ---------------------------------------------------------------------
    logic [3:0][DB_W-1:0] db_cnt;
    logic [3:0][DB_W-1:0] db_cnt_nxt;
    logic [3:0]           sw_db_nxt;

    always_comb begin
        sw_db_nxt  = sw_db;
        db_cnt_nxt = db_cnt;
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (sw_s[i] == sw_db[i]) begin
                    db_cnt_nxt[i] = '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    sw_db_nxt[i]  = sw_s[i];
                    db_cnt_nxt[i] = '0;
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sw_db  <= '0;
            db_cnt <= '0;
        end else begin
            sw_db  <= sw_db_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Pending mask, lowest-index selection and overflow detection
    // ---------------------------------------------------------------------
    logic [3:0] pending;
    logic [3:0] pending_nxt;
    logic [3:0] rise;
    logic       pend_any;
    logic [1:0] pend_idx;
    logic       load;
    logic       load_en;
    logic [3:0] load_clr;
    logic [3:0] held_block;
    logic [3:0] dup;
    logic [3:0] set_ok;
    logic       drop;

    // Rising edge seen on the same edge that sw_db itself rises.
    assign rise = sw_db_nxt & ~sw_db;

    always_comb begin
        pend_any = |pending;
        pend_idx = 2'd0;
        casez (pending)
            4'b???1: pend_idx = 2'd0;
            4'b??10: pend_idx = 2'd1;
            4'b?100: pend_idx = 2'd2;
            4'b1000: pend_idx = 2'd3;
            default: pend_idx = 2'd0;
        endcase
    end

    assign load     = ~cmd_valid | cmd_ready;
    assign load_en  = load & pend_any;
    assign load_clr = load_en ? (4'b0001 << pend_idx) : 4'b0000;

    always_comb begin
        held_block = '0;
        for (int i = 0; i < 4; i++) begin
            held_block[i] = cmd_valid & ~cmd_ready & (cmd_code == 2'(i));
        end
    end

    // A bit leaving pending this cycle is not a duplicate: the new press
    // re-arms it (set wins over the load-clear).
    assign dup         = (pending & ~load_clr) | held_block;
    assign set_ok      = rise & ~dup;
    assign drop        = |(rise & dup);
    assign pending_nxt = (pending & ~load_clr) | set_ok;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Registered output stage; holds while stalled.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 2'd0;
        end else if (load) begin
            cmd_valid <= pend_any;
            if (pend_any) begin
                cmd_code <= pend_idx;
            end
        end
    end

endmodule

// File: tb/tb_sw_cmd_encoder.sv
module tb_sw_cmd_encoder;

    localparam int SAMPLE_DIV   = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       cmd_ready;
    logic       ovf_clr;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [3:0] sw_db;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int xfer_count = 0;

    sw_cmd_encoder #(
        .SAMPLE_DIV  (SAMPLE_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_W       (20)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .sw       (sw),
        .cmd_ready(cmd_ready),
        .ovf_clr  (ovf_clr),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .sw_db    (sw_db),
        .ovf      (ovf)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: switch behaviour in plain integers. Every command the
    // model presents is pushed into exp_q for the monitor.
    // ---------------------------------------------------------------------
    int m_s1[4], m_s2[4], m_db[4], m_dc[4], m_pend[4];
    int m_tcnt = 0, m_valid = 0, m_code = 0, m_ovf = 0;
    int exp_q[$];

    always @(posedge clk_in or negedge rst_n) begin
        int ss[4];
        int rise[4];
        int tick, load, sel, drop;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dc[i] = 0; m_pend[i] = 0;
            end
            m_tcnt = 0; m_valid = 0; m_code = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            tick   = (m_tcnt == SAMPLE_DIV - 1) ? 1 : 0;
            m_tcnt = tick ? 0 : m_tcnt + 1;
            for (int i = 0; i < 4; i++) begin
                ss[i]   = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = (sw[i] === 1'b1) ? 1 : 0;
                rise[i] = 0;
                if (tick) begin
                    if (ss[i] == m_db[i]) m_dc[i] = 0;
                    else if (m_dc[i] == DEBOUNCE_CNT - 1) begin
                        m_db[i] = ss[i];
                        m_dc[i] = 0;
                        rise[i] = ss[i];
                    end else m_dc[i]++;
                end
            end
            load = (!m_valid || cmd_ready) ? 1 : 0;
            sel  = -1;
            if (load) for (int i = 3; i >= 0; i--) if (m_pend[i] != 0) sel = i;
            if (sel >= 0) m_pend[sel] = 0;
            drop = 0;
            for (int i = 0; i < 4; i++) begin
                if (rise[i] != 0) begin
                    if (m_pend[i] != 0 || (m_valid != 0 && m_code == i && !cmd_ready)) drop = 1;
                    else m_pend[i] = 1;
                end
            end
            if (ovf_clr) m_ovf = 0;
            if (drop) m_ovf = 1;
            if (load) begin
                if (sel >= 0) begin
                    m_valid = 1;
                    m_code  = sel;
                    exp_q.push_back(sel);
                end else m_valid = 0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Monitor: at each negedge compare levels, hold stability while stalled,
    // and pop the scoreboard on every transfer the DUT is about to make.
    // ---------------------------------------------------------------------
    int p_valid = 0, p_ready = 0, p_code = 0;

    always @(negedge clk_in) begin
        int dbv, exp_code;
        if (rst_n === 1'b1) begin
            dbv = m_db[0] | (m_db[1] << 1) | (m_db[2] << 2) | (m_db[3] << 3);
            check("sw_db", int'(sw_db), dbv);
            check("ovf", int'(ovf), m_ovf);
            check("cmd_valid", int'(cmd_valid), m_valid);
            if (p_valid != 0 && p_ready == 0)
                check("stall_hold", int'({cmd_valid, cmd_code}), 4 + p_code);
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                xfer_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", int'(cmd_code), -1);
                end else begin
                    exp_code = exp_q.pop_front();
                    check("xfer_code", int'(cmd_code), exp_code);
                end
            end
            p_valid = int'(cmd_valid);
            p_ready = int'(cmd_ready);
            p_code  = int'(cmd_code);
        end else begin
            p_valid = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    initial begin
        int base;
        int hold;
        rst_n     = 1'b0;
        sw        = 4'b1111;
        cmd_ready = 1'b0;
        ovf_clr   = 1'b0;
        step(4);
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_sw_db", int'(sw_db), 0);
        check("rst_ovf", int'(ovf), 0);

        // First press after reset release.
        sw        = 4'b0001;
        cmd_ready = 1'b1;
        base      = xfer_count;
        rst_n     = 1'b1;
        step(30);
        check("first_sw_db", int'(sw_db), 1);
        check("first_xfers", xfer_count - base, 1);
        sw = 4'b0000;
        step(30);

        // Glitch of exactly two sample ticks.
        base = xfer_count;
        sw   = 4'b0010;
        step(2 * SAMPLE_DIV);
        sw = 4'b0000;
        step(40);
        check("glitch_sw_db", int'(sw_db), 0);
        check("glitch_xfers", xfer_count - base, 0);

        // Priority and stall.
        cmd_ready = 1'b0;
        base      = xfer_count;
        sw        = 4'b1010;
        step(30);
        check("prio_valid", int'(cmd_valid), 1);
        check("prio_code", int'(cmd_code), 1);
        step(20);
        check("stall_code", int'(cmd_code), 1);
        cmd_ready = 1'b1;
        step(5);
        check("prio_xfers", xfer_count - base, 2);
        check("prio_idle", int'(cmd_valid), 0);
        sw = 4'b0000;
        step(30);

        // Release generates nothing.
        sw = 4'b0100;
        step(30);
        base = xfer_count;
        sw   = 4'b0000;
        step(30);
        check("release_sw_db", int'(sw_db), 0);
        check("release_xfers", xfer_count - base, 0);

        // Overflow on a repeat press while the first is stalled.
        cmd_ready = 1'b0;
        base      = xfer_count;
        sw        = 4'b0001;
        step(30);
        sw = 4'b0000;
        step(30);
        sw = 4'b0001;
        step(30);
        check("ovf_set", int'(ovf), 1);
        check("ovf_valid", int'(cmd_valid), 1);
        check("ovf_code", int'(cmd_code), 0);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_clr", int'(ovf), 0);
        cmd_ready = 1'b1;
        step(5);
        check("ovf_xfers", xfer_count - base, 1);
        sw = 4'b0000;
        step(30);

        // Async reset while stalled on code 2.
        cmd_ready = 1'b0;
        sw        = 4'b0100;
        step(30);
        check("stall2_valid", int'(cmd_valid), 1);
        check("stall2_code", int'(cmd_code), 2);
        @(posedge clk_in);
        #3 rst_n = 1'b0;
        #1;
        check("async_valid", int'(cmd_valid), 0);
        check("async_code", int'(cmd_code), 0);
        check("async_sw_db", int'(sw_db), 0);
        step(3);
        base      = xfer_count;
        cmd_ready = 1'b1;
        rst_n     = 1'b1;
        step(40);
        check("post_rst_xfers", xfer_count - base, 1);
        sw = 4'b0000;
        step(30);

        // Randomized phase.
        for (int k = 0; k < 250; k++) begin
            sw   = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
                ovf_clr   = ($urandom_range(0, 15) == 0);
                step(1);
            end
        end

        // Drain.
        sw        = 4'b0000;
        ovf_clr   = 1'b0;
        cmd_ready = 1'b1;
        step(60);
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", int'(cmd_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_cmd_encoder.md
Name: sw_cmd_encoder

Overview:
- Front end for the LED shift datapath. Takes 4 raw slide switches and synchronizes and debounces them.
- A rising edge on a debounced switch becomes a queued shift command.
- Commands are delivered to the LED shifter over a valid/ready handshake: this block is the initiator, the shifter is the responder.
- One command per switch press, lowest switch index has priority, no events lost unless overflow is flagged.

Parameters:
- SAMPLE_DIV, 4, clk_in cycles per debounce sample tick (≥2; board build uses 500000 for 10 ms at 50 MHz).
- DEBOUNCE_CNT, 3, consecutive differing sample ticks required before the debounced level changes (≥1).
- CNT_W, 20, width of the tick counter; must satisfy 2^CNT_W ≥ SAMPLE_DIV.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  4  raw switch levels, asynchronous to clk_in.
- cmd_ready  input  1  shifter accepts cmd_code this cycle.
- ovf_clr  input  1  synchronous clear of ovf.
- cmd_valid  output  1  cmd_code holds a valid command.
- cmd_code  output  2  index of the pressed switch (0..3).
- sw_db  output  4  debounced switch levels.
- ovf  output  1  sticky: a press was dropped.

Behaviour:
- Reset (async assert, sync release): synchronizer flops, sw_db, debounce counters, tick counter, pending mask, cmd_valid, cmd_code and ovf are all 0.
- Synchronizer: 2-flop per bit, giving sw_s. Raw-to-sw_s latency is 2 clocks.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick=1 during the cycle where the count equals SAMPLE_DIV-1.
- Debounce, per bit i, evaluated only on tick:
  - sw_s[i]==sw_db[i]: cnt_i←0.
  - sw_s[i]!=sw_db[i] and cnt_i==DEBOUNCE_CNT-1: sw_db[i]←sw_s[i], cnt_i←0.
  - Otherwise: cnt_i←cnt_i+1.
  - A glitch shorter than DEBOUNCE_CNT consecutive ticks never changes sw_db.
- Edge detect: on the clock edge where sw_db[i] goes 0→1, pending[i] is set. A 1→0 change generates nothing.
- Overflow: if the bit being set is already 1 in pending, or equals the index currently held with cmd_valid=1 and not being accepted this cycle, then ovf←1 and no duplicate is queued. ovf clears only on ovf_clr=1. If set and clear happen in the same cycle, set wins.
- Output stage (registered). The stage may load when cmd_valid==0, or when cmd_valid&&cmd_ready:
  - If any pending bit remains after this cycle's clear: cmd_code←index of the lowest set bit, cmd_valid←1, and that pending bit is cleared.
  - Else cmd_valid←0.
- Handshake rules:
  - While cmd_valid=1 and cmd_ready=0, cmd_code is held stable and cmd_valid stays 1.
  - A transfer occurs on each edge where cmd_valid&&cmd_ready. Back-to-back transfers are allowed at 1 per clock.
- Simultaneous events: a new edge for bit j on the same clock that bit j is loaded out of pending is kept, so pending[j] ends at 1 (set wins over the load-clear).
- Minimum latency with SAMPLE_DIV=4, DEBOUNCE_CNT=3 and idle output: sw_db rises on the 3rd tick after sw_s changes. pending sets on that edge, and cmd_valid rises 1 clock later.
- Reset mid-operation: all state clears immediately. A held switch re-debounces after release of reset and produces a fresh command.

Test Plan:
- Reset: rst_n=0 with sw=4'b1111 → cmd_valid=0, sw_db=0, ovf=0. Release rst_n and hold sw=4'b0001 with cmd_ready=1 → sw_db=4'b0001 after 3 ticks, then exactly one transfer with cmd_code=0.
- Glitch: sw[1] high for 2 ticks, then low → sw_db stays 0 and no cmd_valid ever.
- Priority and stall: sw 0000→1010 with cmd_ready=0 → cmd_valid=1, cmd_code=1 held stable for 20 clocks. Then cmd_ready=1 → transfers in order code 1, then code 3, then cmd_valid=0.
- Release ignored: sw 0100→0000 after debounce → sw_db[2] returns to 0 and no command issues.
- Overflow: cmd_ready=0; press sw[0], release, press again (each debounced) → single pending command code 0 and ovf=1. Pulse ovf_clr → ovf=0.
- Async reset mid-stall: cmd_valid=1, cmd_code=2, then drop rst_n mid-cycle → outputs clear without waiting for a clock edge, and the pending mask is empty after release.
